// File: rtl/spi_cmd_arbiter.sv
// spi_cmd_arbiter: arbitrates two command requesters onto one SPI master, one transaction at a time
module spi_cmd_arbiter #(
  parameter int CMD_WIDTH  = 12,
  parameter int READ_WIDTH = 8,
  parameter int TIMEOUT    = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [CMD_WIDTH-1:0]  req0_cmd,
  input  logic                  req0_vld,
  output logic                  req0_rdy,
  output logic                  req0_done,
  output logic [READ_WIDTH-1:0] req0_rdata,
  output logic                  req0_err,
  input  logic [CMD_WIDTH-1:0]  req1_cmd,
  input  logic                  req1_vld,
  output logic                  req1_rdy,
  output logic                  req1_done,
  output logic [READ_WIDTH-1:0] req1_rdata,
  output logic                  req1_err,
  output logic [CMD_WIDTH-1:0]  spi_cmd,
  output logic                  spi_cmd_vld,
  input  logic                  spi_cmd_rdy,
  input  logic                  spi_read_vld,
  input  logic [READ_WIDTH-1:0] spi_read_data,
  output logic                  busy,
  output logic                  owner
);
  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_WR, WAIT_RD} state_e;
  state_e                  state_q, state_d;
  logic [CMD_WIDTH-1:0]    cmd_q, cmd_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    owner_q, owner_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;
  logic [READ_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    gnt, accept, good, tmo;
  // a tie goes to the requester that was not served last; rdy is forced low while in reset
  assign gnt      = (req0_vld && req1_vld) ? !owner_q : req1_vld;
  assign accept   = rst_n && state_q == IDLE && spi_cmd_rdy && (req0_vld || req1_vld);
  assign req0_rdy = accept && !gnt;
  assign req1_rdy = accept && gnt;
  // a write is finished when the master comes back ready after at least one busy cycle
  assign good = (state_q == WAIT_WR && spi_cmd_rdy && cnt_q != '0) || (state_q == WAIT_RD && spi_read_vld);
  assign tmo  = cnt_q == CW'(TIMEOUT - 1);
  assign spi_cmd_vld = state_q == ISSUE;
  assign spi_cmd     = spi_cmd_vld ? cmd_q : '0;
  assign busy        = state_q != IDLE;
  assign owner       = owner_q;
  assign req0_done   = done_q && !owner_q;
  assign req1_done   = done_q && owner_q;
  assign req0_err    = req0_done && err_q;
  assign req1_err    = req1_done && err_q;
  assign req0_rdata  = req0_done ? rdata_q : '0;
  assign req1_rdata  = req1_done ? rdata_q : '0;
  // next state; the completion report is registered so done lands on the first IDLE cycle
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    rdata_d = '0;
    case (state_q)
      IDLE: if (accept) begin
        cmd_d   = gnt ? req1_cmd : req0_cmd;
        owner_d = gnt;
        state_d = ISSUE;
      end
      ISSUE: if (spi_cmd_rdy) begin
        cnt_d   = '0;
        state_d = cmd_q[CMD_WIDTH-1] ? WAIT_WR : WAIT_RD;
      end
      default: begin
        cnt_d = cnt_q + CW'(1);
        if (good || tmo) begin
          state_d = IDLE;
          done_d  = 1'b1;
          err_d   = !good;
          rdata_d = (good && state_q == WAIT_RD) ? spi_read_data : '0;
        end
      end
    endcase
  end
  // registers; reset drops any transaction in flight without reporting it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cmd_q   <= '0;
      cnt_q   <= '0;
      owner_q <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end
endmodule

// File: tb/tb_spi_cmd_arbiter.sv
// tb_spi_cmd_arbiter: directed and randomized checks of spi_cmd_arbiter against a transaction-level model
module tb_spi_cmd_arbiter;
  localparam int CW = 12;
  localparam int RW = 8;
  localparam int TO = 16;
  logic clk = 1'b0;
  logic rst_n;
  logic [CW-1:0] req0_cmd, req1_cmd, spi_cmd, l_spi_cmd;
  logic req0_vld, req1_vld, req0_rdy, req1_rdy, req0_done, req1_done, req0_err, req1_err;
  logic [RW-1:0] req0_rdata, req1_rdata, spi_read_data, l_req0_rdata, l_req1_rdata;
  logic spi_cmd_vld, spi_cmd_rdy, spi_read_vld, busy, owner;
  logic l_req0_rdy, l_req1_rdy, l_req0_done, l_req1_done, l_req0_err, l_req1_err, l_spi_cmd_vld, l_busy, l_owner;
  int checks = 0;
  int errors = 0;
  bit ctl_rand;
  int ctl_lat;
  bit ctl_ret;
  logic [RW-1:0] ctl_data;
  int stray_req;

  always #5 clk = ~clk;

  spi_cmd_arbiter #(.CMD_WIDTH(CW), .READ_WIDTH(RW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_cmd(req0_cmd), .req0_vld(req0_vld), .req0_rdy(req0_rdy), .req0_done(req0_done), .req0_rdata(req0_rdata), .req0_err(req0_err),
    .req1_cmd(req1_cmd), .req1_vld(req1_vld), .req1_rdy(req1_rdy), .req1_done(req1_done), .req1_rdata(req1_rdata), .req1_err(req1_err),
    .spi_cmd(spi_cmd), .spi_cmd_vld(spi_cmd_vld), .spi_cmd_rdy(spi_cmd_rdy),
    .spi_read_vld(spi_read_vld), .spi_read_data(spi_read_data), .busy(busy), .owner(owner));

  // long-timeout copy, used only for the 20-cycle write that the short-timeout instance must abandon
  spi_cmd_arbiter #(.CMD_WIDTH(CW), .READ_WIDTH(RW)) u_long (
    .clk(clk), .rst_n(rst_n),
    .req0_cmd(req0_cmd), .req0_vld(req0_vld), .req0_rdy(l_req0_rdy), .req0_done(l_req0_done), .req0_rdata(l_req0_rdata), .req0_err(l_req0_err),
    .req1_cmd(req1_cmd), .req1_vld(req1_vld), .req1_rdy(l_req1_rdy), .req1_done(l_req1_done), .req1_rdata(l_req1_rdata), .req1_err(l_req1_err),
    .spi_cmd(l_spi_cmd), .spi_cmd_vld(l_spi_cmd_vld), .spi_cmd_rdy(spi_cmd_rdy),
    .spi_read_vld(spi_read_vld), .spi_read_data(spi_read_data), .busy(l_busy), .owner(l_owner));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // transaction-level reference: one outstanding transaction plus the completion report due next cycle
  bit t_on, t_sent, t_owner, m_last, p_on, p_owner, p_err;
  logic [CW-1:0] t_cmd;
  logic [RW-1:0] p_data;
  int t_wait;
  always @(negedge clk) begin : model
    bit take, win, ok, wr;
    if (!rst_n) begin
      t_on = 0; t_sent = 0; m_last = 1; p_on = 0;
      chk("reset_ctl", {req0_rdy, req1_rdy, req0_done, req1_done, req0_err, req1_err, spi_cmd_vld, busy, owner}, 9'b000000001);
      chk("reset_data", {req0_rdata, req1_rdata, spi_cmd}, '0);
    end else begin
      win  = (req0_vld && req1_vld) ? !m_last : req1_vld;
      take = !t_on && spi_cmd_rdy && (req0_vld || req1_vld);
      chk("rdy", {req1_rdy, req0_rdy}, {take && win, take && !win});
      chk("done_err", {req1_done, req0_done, req1_err, req0_err},
          {p_on && p_owner, p_on && !p_owner, p_on && p_owner && p_err, p_on && !p_owner && p_err});
      chk("rdata0", req0_rdata, (p_on && !p_owner) ? p_data : '0);
      chk("rdata1", req1_rdata, (p_on && p_owner) ? p_data : '0);
      chk("spi_cmd", {spi_cmd_vld, spi_cmd}, (t_on && !t_sent) ? {1'b1, t_cmd} : '0);
      chk("busy_owner", {busy, owner}, {t_on, m_last});
      p_on = 0;
      if (!t_on) begin
        if (take) begin
          t_on = 1; t_sent = 0; t_owner = win; m_last = win;
          t_cmd = win ? req1_cmd : req0_cmd;
        end
      end else if (!t_sent) begin
        if (spi_cmd_rdy) begin t_sent = 1; t_wait = 0; end
      end else begin
        wr = t_cmd[CW-1];
        ok = wr ? (spi_cmd_rdy && t_wait > 0) : spi_read_vld;
        if (ok || t_wait == TO - 1) begin
          p_on = 1; p_owner = t_owner; p_err = !ok;
          p_data = (ok && !wr) ? spi_read_data : '0;
          t_on = 0;
        end else t_wait++;
      end
    end
  end

  // SPI master: drops rdy for a latency after each accepted command, returns read data in its last busy cycle
  initial begin : master
    bit hs, rd, m_rd, m_ret;
    int left, stray_seen;
    logic [RW-1:0] m_data;
    left = 0; stray_seen = 0; m_rd = 0; m_ret = 0; m_data = '0;
    spi_cmd_rdy = 1; spi_read_vld = 0; spi_read_data = '0;
    forever begin
      @(negedge clk);
      hs = rst_n && spi_cmd_vld && spi_cmd_rdy;
      rd = !spi_cmd[CW-1];
      @(posedge clk);
      #2;
      spi_read_vld = 0;
      if (!rst_n) begin
        left = 0; spi_cmd_rdy = 1;
      end else begin
        if (hs) begin
          m_rd   = rd;
          left   = ctl_rand ? int'($urandom_range(1, 24)) : ctl_lat;
          m_ret  = ctl_rand ? ($urandom_range(0, 99) < 85) : ctl_ret;
          m_data = ctl_rand ? RW'($urandom) : ctl_data;
        end
        if (left > 0) begin
          spi_cmd_rdy = 0;
          left--;
          if (left == 0 && m_rd && m_ret) begin spi_read_vld = 1; spi_read_data = m_data; end
        end else spi_cmd_rdy = 1;
        if (stray_req != stray_seen) begin stray_seen = stray_req; spi_read_vld = 1; spi_read_data = 8'hEE; end
        if (ctl_rand && $urandom_range(0, 15) == 0) begin spi_read_vld = 1; spi_read_data = RW'($urandom); end
      end
    end
  end

  task automatic issue(input bit who, input logic [CW-1:0] cmd);
    bit ok;
    @(posedge clk); #1;
    if (who) begin req1_cmd = cmd; req1_vld = 1; end else begin req0_cmd = cmd; req0_vld = 1; end
    ok = 0;
    for (int i = 0; i < 64 && !ok; i++) begin @(negedge clk); ok = who ? req1_rdy : req0_rdy; end
    chk("accept", ok, 1);
    @(posedge clk); #1;
    req0_vld = 0; req1_vld = 0;
    ok = 0;
    for (int i = 0; i < 64 && !ok; i++) begin @(negedge clk); ok = spi_cmd_vld && spi_cmd_rdy; end
    chk("handshake", ok, 1);
  endtask

  task automatic wait_done(input bit who, input int lim, output int n, output logic [RW-1:0] d, output bit e);
    n = -1; d = '0; e = 0;
    for (int i = 0; i < lim && n < 0; i++) begin
      @(negedge clk);
      if (who ? req1_done : req0_done) begin
        n = i; d = who ? req1_rdata : req0_rdata; e = who ? req1_err : req0_err;
      end
    end
  endtask

  initial begin : director
    int n, n_main, n_long, k, dn;
    bit e, e_main;
    logic [RW-1:0] d;
    logic [35:0] lv;
    logic [3:0] order;
    rst_n = 0; req0_vld = 0; req1_vld = 0; req0_cmd = '0; req1_cmd = '0;
    ctl_rand = 0; ctl_lat = 1; ctl_ret = 1; ctl_data = '0; stray_req = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    // write held off 20 cycles: short-timeout copy gives up at count 15, long copy completes after rdy returns
    ctl_lat = 20;
    issue(1, 12'h8F0);
    n_main = -1; n_long = -1; e_main = 0; lv = '1;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (req1_done && n_main < 0) begin n_main = i; e_main = req1_err; end
      if (l_req1_done && n_long < 0) begin
        n_long = i;
        lv = {l_req1_rdata, l_req0_rdata, l_spi_cmd, l_req1_err, l_req0_err, l_req0_done, l_req0_rdy, l_req1_rdy, l_spi_cmd_vld, l_busy, l_owner};
      end
    end
    chk("wr_timeout_cycle", n_main, TO);
    chk("wr_timeout_err", e_main, 1);
    chk("wr_done_cycle", n_long, 21);
    chk("wr_done_outs", lv, 36'h1);
    // read 0x0A5 returning 0x3C
    ctl_lat = 3; ctl_ret = 1; ctl_data = 8'h3C;
    issue(0, 12'h0A5);
    wait_done(0, 40, n, d, e);
    chk("rd_cycle", n, 3);
    chk("rd_data", d, 8'h3C);
    chk("rd_err", e, 0);
    chk("rd_other", {req1_done, req1_err, req1_rdata}, '0);
    @(negedge clk);
    chk("rd_pulse_len", req0_done, 0);
    // read that never gets data, then a normal read
    ctl_lat = 20; ctl_ret = 0;
    issue(0, 12'h055);
    wait_done(0, 40, n, d, e);
    chk("to_cycle", n, TO);
    chk("to_err", e, 1);
    chk("to_data", d, 0);
    ctl_lat = 2; ctl_ret = 1; ctl_data = 8'hA7;
    issue(1, 12'h011);
    wait_done(1, 40, n, d, e);
    chk("rd2_cycle", n, 2);
    chk("rd2_data", d, 8'hA7);
    chk("rd2_err", e, 0);
    // stray read pulse during a write, then one while idle
    ctl_lat = 6;
    issue(0, 12'h8A1);
    @(negedge clk);
    @(negedge clk);
    stray_req++;
    @(negedge clk);
    @(negedge clk);
    chk("stray_busy", {busy, req0_done}, 2'b10);
    wait_done(0, 20, n, d, e);
    chk("stray_wr_cycle", n, 3);
    chk("stray_wr_data", d, 0);
    chk("stray_wr_err", e, 0);
    @(posedge clk); #1 stray_req++;
    @(negedge clk);
    @(negedge clk);
    chk("idle_stray", {busy, req0_done, req1_done}, 3'b000);
    // reset while waiting for read data
    ctl_lat = 30; ctl_ret = 0;
    issue(1, 12'h022);
    repeat (3) @(negedge clk);
    chk("abort_pre_busy", busy, 1);
    @(posedge clk); #1 rst_n = 0;
    @(negedge clk);
    chk("abort_busy", {busy, req1_done, req0_done}, 3'b000);
    @(posedge clk); #1 rst_n = 1;
    dn = 0;
    repeat (20) begin @(negedge clk); dn += int'(req0_done) + int'(req1_done); end
    chk("abort_no_done", dn, 0);
    // persistent tie after reset alternates starting with req0
    ctl_lat = 2;
    @(posedge clk); #1;
    req0_cmd = 12'h8A0; req1_cmd = 12'h8B1; req0_vld = 1; req1_vld = 1;
    k = 0; order = '0;
    for (int i = 0; i < 200 && k < 4; i++) begin
      @(negedge clk);
      if (req0_rdy || req1_rdy) begin order[k] = req1_rdy; k++; end
    end
    @(posedge clk); #1;
    req0_vld = 0; req1_vld = 0;
    chk("tie_count", k, 4);
    chk("tie_order", order, 4'b1010);
    // randomized traffic, master latencies and occasional resets
    ctl_rand = 1;
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #1;
      rst_n = ($urandom_range(0, 499) != 0);
      req0_vld = ($urandom_range(0, 2) == 0);
      req1_vld = ($urandom_range(0, 2) == 0);
      req0_cmd = CW'($urandom);
      req1_cmd = CW'($urandom);
    end
    @(posedge clk); #1;
    rst_n = 1; req0_vld = 0; req1_vld = 0;
    repeat (40) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: run still active at %0t, limit 1000000", $time);
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/spi_cmd_arbiter.md
SPI_CMD_ARBITER -- requirements
Module: spi_cmd_arbiter

Interface
REQ-001 The block SHALL have parameter CMD_WIDTH, default 12, the command word width; the command MSB is 1 for write and 0 for read.
REQ-002 The block SHALL have parameter READ_WIDTH, default 8, the read data width.
REQ-003 The block SHALL have parameter TIMEOUT, default 1024, the maximum number of wait cycles for one transaction.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have ports req0_cmd / req1_cmd, input, CMD_WIDTH bits: requester command words.
REQ-007 The block SHALL have ports req0_vld / req1_vld, input, 1 bit: requester command valid.
REQ-008 The block SHALL have ports req0_rdy / req1_rdy, output, 1 bit: command accepted when vld and rdy are both high.
REQ-009 The block SHALL have ports req0_done / req1_done, output, 1 bit: one-cycle transaction-complete pulse.
REQ-010 The block SHALL have ports req0_rdata / req1_rdata, output, READ_WIDTH bits: read result, valid while done is high.
REQ-011 The block SHALL have ports req0_err / req1_err, output, 1 bit: timeout flag, valid while done is high.
REQ-012 The block SHALL have port spi_cmd, output, CMD_WIDTH bits: command to the SPI master.
REQ-013 The block SHALL have port spi_cmd_vld, output, 1 bit: command valid to the SPI master.
REQ-014 The block SHALL have port spi_cmd_rdy, input, 1 bit: SPI master idle/ready; the master drops it the cycle after acceptance until its transfer ends.
REQ-015 The block SHALL have ports spi_read_vld (input, 1 bit) and spi_read_data (input, READ_WIDTH bits): read return from the SPI master.
REQ-016 The block SHALL have ports busy (output, 1 bit, high when not IDLE) and owner (output, 1 bit, index of the current or last grant).

Function
REQ-017 The FSM SHALL have states IDLE, ISSUE, WAIT_WR and WAIT_RD; only one transaction is outstanding at a time.
REQ-018 In IDLE with spi_cmd_rdy=1, the grant SHALL be combinational: the single valid requester wins; if both are valid, the requester not equal to owner wins.
REQ-019 reqN_rdy SHALL be high only in IDLE, with spi_cmd_rdy=1, and grant=N; no other rdy is high in that cycle.
REQ-020 On acceptance, the block SHALL latch the command into an internal register, set owner=N, and go to ISSUE next cycle.
REQ-021 In ISSUE, the block SHALL drive spi_cmd_vld=1 and spi_cmd=latched command, and hold both stable until spi_cmd_vld and spi_cmd_rdy are both high.
REQ-022 On that handshake, the block SHALL go to WAIT_WR if the command MSB=1, else WAIT_RD, and clear the wait counter.
REQ-023 In WAIT_WR, the block SHALL ignore spi_cmd_rdy in the first cycle; the first later cycle with spi_cmd_rdy=1 is a good completion.
REQ-024 In WAIT_RD, the cycle with spi_read_vld=1 is a good completion; the block SHALL capture spi_read_data at that cycle.
REQ-025 On completion, the block SHALL raise owner's done for exactly one cycle, registered (the cycle after the completion event), and return to IDLE in that same done cycle.
REQ-026 On a read done, rdata SHALL equal the captured data; on a write done, rdata SHALL equal 0.
REQ-027 The wait counter SHALL increment each cycle in WAIT_WR and WAIT_RD; on reaching TIMEOUT-1 without completion, the block SHALL complete with err=1 and rdata=0.
REQ-028 If a completion and the timeout occur in the same cycle, the completion SHALL win with err=0.
REQ-029 spi_read_vld SHALL be ignored outside WAIT_RD; in particular, a stray pulse in WAIT_WR or IDLE has no effect.
REQ-030 A requester SHALL be able to present a new command while its done is high; acceptance then follows the normal IDLE rules.
REQ-031 The non-owner's done, rdata and err SHALL always be 0.

Reset
REQ-032 When rst_n=0, asynchronously: state=IDLE; owner=1 (so req0 wins the first tie); counter=0; latched command=0.
REQ-033 When rst_n=0, all outputs SHALL be 0 (rdy, done, err, rdata, spi_cmd, spi_cmd_vld, busy).
REQ-034 Reset mid-transaction SHALL abort the transaction without any done pulse.

Verification
REQ-035 Read: req0 sends 0x0A5, master returns 0x3C -> req0_done for one cycle with req0_rdata=0x3C and req0_err=0; req1 outputs stay 0.
REQ-036 Write: req1 sends 0x8F0, master drops rdy for 20 cycles -> req1_done one cycle after rdy returns, with rdata=0 and err=0.
REQ-037 Tie: both valid with owner=1 -> req0 granted first, then req1 on the next IDLE; back-to-back ties alternate 0,1,0,1.
REQ-038 Timeout: TIMEOUT=16, a read that gets no spi_read_vld -> done at wait count 15 with err=1 and rdata=0; a later read completes normally.
REQ-039 Stray pulse: spi_read_vld pulsed during WAIT_WR -> no change; the write then completes normally.
REQ-040 Abort: rst_n pulsed low during WAIT_RD -> busy=0 and no done; afterwards the grant order starts with req0.
